// File: rtl/branch_ctrl_pkg.sv
// Shared types and defaults for the branch redirect controller.
package branch_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    BRC_IDLE,
    BRC_WAIT_DS,
    BRC_REDIRECT
  } brc_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_stats.sv
// branch_stats: saturating taken/not-taken counters, cleared only by rst.
module branch_stats #(
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_taken,
  input  logic              inc_not_taken,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else begin
      if (inc_taken && (stat_taken != '1))
        stat_taken <= stat_taken + STAT_W'(1);
      if (inc_not_taken && (stat_not_taken != '1))
        stat_not_taken <= stat_not_taken + STAT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns an EX-stage taken branch into a valid/ready fetch redirect after the delay slot exists.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_stall,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_addr,
  input  logic              ds_valid,
  input  logic              exc_flush,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              stall_ex,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  brc_state_t state, state_next;
  logic       accept;
  logic       fire;

  always_comb begin
    accept   = ex_valid & ex_is_branch & ~ex_stall & (state == BRC_IDLE) & ~exc_flush;
    // exception owns the flush, so a coincident handshake is not a fire
    fire     = redirect_valid & redirect_ready & ~exc_flush;
    flush_if = fire;
    stall_ex = ex_valid & ex_is_branch & (state != BRC_IDLE) & ~exc_flush;
  end

  always_comb begin
    state_next = state;
    if (exc_flush) begin
      state_next = BRC_IDLE;
    end else begin
      unique case (state)
        BRC_IDLE:
          if (accept && ex_branch_taken)
            state_next = ds_valid ? BRC_REDIRECT : BRC_WAIT_DS;
        BRC_WAIT_DS:
          if (ds_valid)
            state_next = BRC_REDIRECT;
        BRC_REDIRECT:
          if (fire)
            state_next = BRC_IDLE;
        default:
          state_next = BRC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BRC_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      redirect_valid <= (state_next == BRC_REDIRECT);
      if (exc_flush)
        redirect_pc <= '0;
      else if (accept && ex_branch_taken)
        redirect_pc <= ex_branch_addr;
    end
  end

`ifdef BRANCH_STATS_EN
  branch_stats #(
    .STAT_W(STAT_W)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .inc_taken     (accept & ex_branch_taken),
    .inc_not_taken (accept & ~ex_branch_taken),
    .stat_taken    (stat_taken),
    .stat_not_taken(stat_not_taken)
  );
`else
  assign stat_taken     = '0;
  assign stat_not_taken = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed and random stimulus for branch_redirect_ctrl against a pending-redirect reference model.
module tb_branch_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam int STAT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_is_branch, ex_stall, ex_branch_taken;
  logic [ADDR_W-1:0] ex_branch_addr;
  logic              ds_valid, exc_flush, redirect_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_if, stall_ex;
  logic [STAT_W-1:0] stat_taken, stat_not_taken;

  int checks = 0;
  int errors = 0;

  // Model: a taken branch is "owed" (m_pend) until fetch takes it; it is
  // offered to fetch (m_vis) once the delay slot has been seen.
  bit                m_pend, m_vis, m_pc_zero;
  logic [ADDR_W-1:0] m_tgt;
  int                m_t, m_nt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .ADDR_W(ADDR_W),
    .STAT_W(STAT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_stall       (ex_stall),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_addr (ex_branch_addr),
    .ds_valid       (ds_valid),
    .exc_flush      (exc_flush),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .stall_ex       (stall_ex),
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int c);
    int mx;
    mx = (1 << STAT_W) - 1;
    return (c > mx) ? 64'(mx) : 64'(c);
  endfunction

  task automatic step(input logic r, input logic v, input logic br, input logic st,
                      input logic tk, input logic [ADDR_W-1:0] a, input logic ds,
                      input logic ex, input logic rdy);
    logic acc, fire;
    @(negedge clk);
    rst = r; ex_valid = v; ex_is_branch = br; ex_stall = st; ex_branch_taken = tk;
    ex_branch_addr = a; ds_valid = ds; exc_flush = ex; redirect_ready = rdy;
    #1;
    fire = m_vis & rdy & ~ex;
    acc  = v & br & ~st & ~m_pend & ~ex;
    check("redirect_valid", redirect_valid, m_vis);
    if (m_vis)          check("redirect_pc", redirect_pc, m_tgt);
    else if (m_pc_zero) check("redirect_pc_reset", redirect_pc, '0);
    check("flush_if", flush_if, fire);
    check("stall_ex", stall_ex, v & br & m_pend & ~ex);
`ifdef BRANCH_STATS_EN
    check("stat_taken", stat_taken, sat(m_t));
    check("stat_not_taken", stat_not_taken, sat(m_nt));
`else
    check("stat_taken", stat_taken, '0);
    check("stat_not_taken", stat_not_taken, '0);
`endif
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_vis = 0; m_pc_zero = 1; m_t = 0; m_nt = 0;
    end else begin
      if (acc) begin
        if (tk) m_t++;
        else    m_nt++;
      end
      if (ex) begin
        m_pend = 0; m_vis = 0;
      end else if (fire) begin
        m_pend = 0; m_vis = 0;
      end else if (m_pend && !m_vis && ds) begin
        m_vis = 1;
      end else if (acc && tk) begin
        m_pend = 1; m_vis = ds; m_tgt = a; m_pc_zero = 0;
      end
    end
  endtask

  task automatic idle(input logic ds, input logic rdy);
    step(0, 0, 0, 0, 0, '0, ds, 0, rdy);
  endtask

  task automatic branch(input logic tk, input logic [ADDR_W-1:0] a, input logic ds, input logic rdy);
    step(0, 1, 1, 0, tk, a, ds, 0, rdy);
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_is_branch = 0; ex_stall = 0; ex_branch_taken = 0;
    ex_branch_addr = '0; ds_valid = 0; exc_flush = 0; redirect_ready = 0;
    repeat (2) @(posedge clk);
    m_pend = 0; m_vis = 0; m_pc_zero = 1; m_tgt = '0; m_t = 0; m_nt = 0;

    // Reset state, with a stalled branch present so nothing is accepted
    @(negedge clk);
    rst = 0; ex_valid = 1; ex_is_branch = 1; ex_stall = 1;
    #1;
    check("reset_valid", redirect_valid, 1'b0);
    check("reset_pc", redirect_pc, '0);
    check("reset_flush", flush_if, 1'b0);
    check("reset_stall", stall_ex, 1'b0);
    check("reset_stat_t", stat_taken, '0);
    check("reset_stat_nt", stat_not_taken, '0);

    // 1: not taken
    branch(0, 32'h1234_5678, 1, 1);
    idle(1, 1); idle(1, 1);

    // 2: taken with delay slot present
    branch(1, 32'h8000_0100, 1, 1);
    idle(1, 1); idle(1, 1);

    // 3: waiting on the delay slot
    branch(1, 32'h8000_0200, 0, 1);
    repeat (3) idle(0, 1);
    idle(1, 0);
    idle(1, 1); idle(1, 1);

    // 4: fetch backpressure with a second branch held in EX
    branch(1, 32'h8000_0300, 1, 0);
    repeat (4) branch(1, 32'h8000_0400, 1, 0);
    branch(1, 32'h8000_0400, 1, 1);
    branch(1, 32'h8000_0400, 1, 0);
    idle(1, 1); idle(1, 1);

    // 5: exception in WAIT_DS, then in REDIRECT together with ready
    branch(1, 32'h8000_0500, 0, 1);
    step(0, 1, 1, 0, 1, 32'h8000_0600, 0, 1, 1);
    idle(1, 1);
    branch(1, 32'h8000_0700, 1, 0);
    step(0, 0, 0, 0, 0, '0, 1, 1, 1);
    idle(1, 1); idle(1, 1);

    // 6: reset mid-REDIRECT, then counter saturation
    branch(1, 32'h8000_0800, 1, 0);
    idle(1, 0);
    step(1, 0, 0, 0, 0, '0, 1, 0, 1);
    idle(1, 1);
    for (int i = 0; i < 5; i++) begin
      branch(1, 32'h9000_0000 + 32'(i), 1, 1);
      idle(1, 1);
    end
    idle(1, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 70), ($urandom_range(99) < 60),
           ($urandom_range(99) < 15), $urandom_range(1), $urandom,
           ($urandom_range(99) < 50), ($urandom_range(99) < 5), ($urandom_range(99) < 50));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
